// File: rtl/pipeline_ifp_stage.sv
// Fetch-prepare stage: owns the fetch PC, picks the ROM/DRAM channel,
// issues DRAM read pulses, applies redirects and holds under stall.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall                      hold request from hazard logic / IFR
//   redirect_valid/_pc         branch/jump/trap redirect
//   dram_data_ready            DRAM fetch data valid
//   pc_IFP                     current fetch PC
//   if_channel_sel             1=DRAM, 0=ROM (from pc_IFP)
//   rom_addr, dram_addr        fetch address, equal to pc_IFP
//   dram_read_req              one-cycle DRAM read pulse
//   fetch_valid                0 marks pc_IFP as a bubble
//   redirect_misaligned        pulse: applied redirect had low bits set
module pipeline_ifp_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] DRAM_BASE  = 64'h0000_0000_8000_0000,
  parameter int          INST_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        dram_data_ready,
  output logic [63:0] pc_IFP,
  output logic        if_channel_sel,
  output logic [63:0] rom_addr,
  output logic [63:0] dram_addr,
  output logic        dram_read_req,
  output logic        fetch_valid,
  output logic        redirect_misaligned
);

  typedef enum logic [1:0] {
    S_RUN,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [63:0] STEP = 64'(INST_BYTES);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        fv_q, fv_d;
  logic        mis_q, mis_d;
  logic        pend_v_q, pend_v_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic        pend_mis_q, pend_mis_d;
  logic        defer_q, defer_d;

  logic [63:0] rd_pc;
  logic        rd_mis;
  logic [63:0] ret_pc;
  logic        ret_fv;
  logic        ret_mis;

  assign rd_pc  = {redirect_pc[63:2], 2'b00};
  assign rd_mis = |redirect_pc[1:0];

  // Where the PC goes once a DRAM fetch completes: a redirect that
  // arrived meanwhile squashes the returned instruction.
  always_comb begin
    ret_pc  = pc_q + STEP;
    ret_fv  = 1'b1;
    ret_mis = 1'b0;
    if (pend_v_q) begin
      ret_pc  = pend_pc_q;
      ret_fv  = 1'b0;
      ret_mis = pend_mis_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fv_d       = fv_q;
    mis_d      = 1'b0;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    pend_mis_d = pend_mis_q;
    defer_d    = defer_q;
    unique case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          pc_d     = rd_pc;
          mis_d    = rd_mis;
          fv_d     = 1'b1;
          defer_d  = 1'b0;
          pend_v_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (defer_q) begin
          pc_d     = ret_pc;
          fv_d     = ret_fv;
          mis_d    = ret_mis;
          defer_d  = 1'b0;
          pend_v_d = 1'b0;
        end else if (if_channel_sel) begin
          state_d = S_REQ;
          fv_d    = 1'b1;
        end else begin
          pc_d = pc_q + STEP;
          fv_d = 1'b1;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        if (redirect_valid) begin
          pend_v_d   = 1'b1;
          pend_pc_d  = rd_pc;
          pend_mis_d = rd_mis;
        end
      end
      S_WAIT: begin
        if (dram_data_ready && redirect_valid) begin
          state_d  = S_RUN;
          pc_d     = rd_pc;
          mis_d    = rd_mis;
          fv_d     = 1'b0;
          pend_v_d = 1'b0;
        end else begin
          if (redirect_valid) begin
            pend_v_d   = 1'b1;
            pend_pc_d  = rd_pc;
            pend_mis_d = rd_mis;
          end
          if (dram_data_ready) begin
            state_d = S_RUN;
            if (stall) begin
              defer_d = 1'b1;
            end else begin
              pc_d     = ret_pc;
              fv_d     = ret_fv;
              mis_d    = ret_mis;
              pend_v_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      fv_q       <= 1'b0;
      mis_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= 64'h0;
      pend_mis_q <= 1'b0;
      defer_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fv_q       <= fv_d;
      mis_q      <= mis_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      pend_mis_q <= pend_mis_d;
      defer_q    <= defer_d;
    end
  end

  assign pc_IFP              = pc_q;
  assign if_channel_sel      = (pc_q >= DRAM_BASE);
  assign rom_addr            = pc_q;
  assign dram_addr           = pc_q;
  assign dram_read_req       = (state_q == S_REQ);
  assign fetch_valid         = fv_q;
  assign redirect_misaligned = mis_q;

endmodule
